// File: rtl/mat_buf_seq_pkg.sv
// Shared types for the matrix buffer sequencer.
// Only the FSM state enum lives here; sizes are derived locally from DIM.
package mat_buf_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mat_buf_seq_rc_counter.sv
// DIM-modulo row/column index pair for walking a DIM x DIM matrix.
// Column is the fast index; last flags the final (DIM-1, DIM-1) position.
module mat_buf_seq_rc_counter #(
    parameter int DIM = 4,
    parameter int CW  = $clog2(DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [CW-1:0] MAX_IDX = CW'(DIM - 1);

    logic [CW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic          col_end_s;
    logic          row_end_s;

    assign col_end_s = (col_r == MAX_IDX);
    assign row_end_s = (row_r == MAX_IDX);
    assign row       = row_r;
    assign col       = col_r;
    assign last      = col_end_s & row_end_s;

    // Index registers: clear wins over enable, column carries into row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r <= {CW{1'b0}};
            col_r <= {CW{1'b0}};
        end else if (clr) begin
            row_r <= {CW{1'b0}};
            col_r <= {CW{1'b0}};
        end else if (en) begin
            if (col_end_s) begin
                col_r <= {CW{1'b0}};
                row_r <= row_end_s ? {CW{1'b0}} : row_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                col_r <= col_r + {{(CW-1){1'b0}}, 1'b1};
                row_r <= row_r;
            end
        end else begin
            row_r <= row_r;
            col_r <= col_r;
        end
    end

endmodule

// File: rtl/mat_buf_seq.sv
// Matrix buffer sequencer: loads a DIM x DIM matrix row-major into an external
// memory, then streams it back row-major or transposed (column-major).
module mat_buf_seq
    import mat_buf_seq_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DIM       = 4,
    parameter int AW        = $clog2(DIM * DIM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 transpose_i,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [AW-1:0]        w_addr_o,
    output logic [DATA_SIZE-1:0] w_data_o,
    output logic                 w_en_o,
    output logic [AW-1:0]        r_addr_o,
    input  logic [DATA_SIZE-1:0] r_data_i,
    output logic [DATA_SIZE-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int            DEPTH  = DIM * DIM;
    localparam int            CW     = $clog2(DIM);
    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DIM_A  = AW'(DIM);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] wcnt_r;
    logic          transpose_r;
    logic          start_acc_s;
    logic          load_beat_s;
    logic          rd_hs_s;
    logic [CW-1:0] row_s;
    logic [CW-1:0] col_s;
    logic          rc_last_s;
    logic [AW-1:0] row_ext_s;
    logic [AW-1:0] col_ext_s;

    assign start_acc_s = (state_r == IDLE) & start_i;
    assign load_beat_s = (state_r == LOAD) & in_valid_i;
    assign rd_hs_s     = (state_r == READ) & out_ready_i;

    mat_buf_seq_rc_counter #(
        .DIM (DIM),
        .CW  (CW)
    ) u_rc (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc_s),
        .en   (rd_hs_s),
        .row  (row_s),
        .col  (col_s),
        .last (rc_last_s)
    );

    assign row_ext_s = AW'(row_s);
    assign col_ext_s = AW'(col_s);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; start is only looked at while idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) state_nxt_s = LOAD;
                else         state_nxt_s = IDLE;
            end
            LOAD: begin
                if (in_valid_i && (wcnt_r == LAST_A)) state_nxt_s = READ;
                else                                  state_nxt_s = LOAD;
            end
            READ: begin
                if (out_ready_i && rc_last_s) state_nxt_s = DONE;
                else                          state_nxt_s = READ;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Write pointer, wrapping after the final element of a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r <= {AW{1'b0}};
        end else if (start_acc_s) begin
            wcnt_r <= {AW{1'b0}};
        end else if (load_beat_s) begin
            wcnt_r <= (wcnt_r == LAST_A) ? {AW{1'b0}} : wcnt_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Read order is fixed for the whole cycle once start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            transpose_r <= 1'b0;
        end else if (start_acc_s) begin
            transpose_r <= transpose_i;
        end else begin
            transpose_r <= transpose_r;
        end
    end

    assign in_ready_o  = (state_r == LOAD);
    assign w_en_o      = load_beat_s;
    assign w_addr_o    = wcnt_r;
    assign w_data_o    = in_data_i;
    assign out_valid_o = (state_r == READ);
    assign out_last_o  = (state_r == READ) & rc_last_s;
    assign out_data_o  = r_data_i;
    assign busy_o      = (state_r == LOAD) | (state_r == READ);
    assign done_o      = (state_r == DONE);
    // Transposed read swaps the roles of row and column in the row-major address.
    assign r_addr_o    = transpose_r ? (col_ext_s * DIM_A + row_ext_s)
                                     : (row_ext_s * DIM_A + col_ext_s);

endmodule

// File: tb/tb_mat_buf_seq.sv
// Self-checking bench for mat_buf_seq at DIM=2 with a behavioural memory beside it.
module tb_mat_buf_seq;

    localparam int DS    = 8;
    localparam int DIM   = 2;
    localparam int DEPTH = DIM * DIM;
    localparam int AW    = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          transpose;
    logic [DS-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] w_addr;
    logic [DS-1:0] w_data;
    logic          w_en;
    logic [AW-1:0] r_addr;
    logic [DS-1:0] r_data;
    logic [DS-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DS-1:0] mem [DEPTH];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [DS-1:0] d  [DEPTH];
        logic          tr;
        logic [DS-1:0] ed [DEPTH];
        logic [AW-1:0] ea [DEPTH];
    } vec_t;

    vec_t tbl [3];

    mat_buf_seq #(.DATA_SIZE(DS), .DIM(DIM), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .transpose_i (transpose),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .w_addr_o    (w_addr),
        .w_data_o    (w_data),
        .w_en_o      (w_en),
        .r_addr_o    (r_addr),
        .r_data_i    (r_data),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (w_en) mem[w_addr] <= w_data;
    assign r_data = mem[r_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_w_en"}, w_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_w_addr"}, w_addr, 0);
        chk({tag, "_r_addr"}, r_addr, 0);
    endtask

    // Output matrix is M or M^T; stream it row-major and find where each element lives in M.
    task automatic model(input logic [DS-1:0] d [DEPTH], input logic tr,
                         output logic [DS-1:0] ed [DEPTH], output logic [AW-1:0] ea [DEPTH]);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                int src;
                src = tr ? (c * DIM + r) : (r * DIM + c);
                ea[r * DIM + c] = AW'(src);
                ed[r * DIM + c] = d[src];
            end
        end
    endtask

    task automatic do_txn(input logic [DS-1:0] d [DEPTH], input logic tr,
                          input logic [DS-1:0] ed [DEPTH], input logic [AW-1:0] ea [DEPTH],
                          input int gap_pct, input int rdy_pct, input int stall_at,
                          input logic do_start, input logic poke, input int abort_at);
        int   idx;
        int   k;
        int   guard;
        int   stall_left;
        logic stall_used;
        logic v;
        logic rdy;
        if (do_start) begin
            start = 1'b1; transpose = tr; in_valid = 1'b0;
            #1;
            chk("idle_in_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
            tick();
            start = 1'b0;
        end
        idx = 0; guard = 0;
        while (idx < DEPTH && guard < 200) begin
            v         = ($urandom_range(99) >= gap_pct);
            in_valid  = v;
            in_data   = v ? d[idx] : DS'($urandom);
            start     = poke & 1'($urandom_range(1));
            transpose = ~tr;
            out_ready = 1'($urandom_range(1));
            #1;
            chk("load_in_ready", in_ready, 1);
            chk("load_w_en", w_en, v);
            if (v) chk("load_w_addr", w_addr, idx);
            chk("load_out_valid", out_valid, 0);
            chk("load_busy", busy, 1);
            tick();
            if (v) idx++;
            guard++;
        end
        if (idx < DEPTH) chk("load_timeout", idx, DEPTH);
        in_valid = 1'b0; start = 1'b0;
        k = 0; guard = 0; stall_left = 0; stall_used = 1'b0;
        while (k < DEPTH && guard < 200) begin
            if (k == stall_at && !stall_used) begin
                stall_used = 1'b1;
                stall_left = 3;
            end
            rdy = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (stall_left > 0) stall_left--;
            out_ready = rdy;
            start     = poke & 1'($urandom_range(1));
            in_valid  = 1'($urandom_range(1));
            #1;
            chk("read_out_valid", out_valid, 1);
            chk("read_in_ready", in_ready, 0);
            chk("read_w_en", w_en, 0);
            chk("read_busy", busy, 1);
            chk("read_done", done, 0);
            chk("read_r_addr", r_addr, ea[k]);
            chk("read_out_data", out_data, ed[k]);
            chk("read_out_last", out_last, (k == DEPTH - 1));
            if (k == abort_at) begin
                rst = 1'b1; start = 1'b0; in_valid = 1'b0;
                #1;
                chk_reset_outs("abort");
                rst = 1'b0;
                tick();
                chk("abort_idle_ready", in_ready, 0);
                chk("abort_idle_busy", busy, 0);
                return;
            end
            tick();
            if (rdy) k++;
            guard++;
        end
        if (k < DEPTH) chk("read_timeout", k, DEPTH);
        out_ready = 1'b0; in_valid = 1'b0; start = poke;
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_out_valid", out_valid, 0);
        tick();
        start = 1'b0;
        #1;
        chk("done_once", done, 0);
        chk("post_done_idle", in_ready, 0);
        chk("post_done_busy", busy, 0);
    endtask

    initial begin
        logic [DS-1:0] rd [DEPTH];
        logic [DS-1:0] red [DEPTH];
        logic [AW-1:0] rea [DEPTH];
        logic          rtr;

        tbl[0].d = '{8'h11, 8'h22, 8'h33, 8'h44}; tbl[0].tr = 1'b0;
        tbl[0].ed = '{8'h11, 8'h22, 8'h33, 8'h44}; tbl[0].ea = '{2'd0, 2'd1, 2'd2, 2'd3};
        tbl[1].d = '{8'h11, 8'h22, 8'h33, 8'h44}; tbl[1].tr = 1'b1;
        tbl[1].ed = '{8'h11, 8'h33, 8'h22, 8'h44}; tbl[1].ea = '{2'd0, 2'd2, 2'd1, 2'd3};
        tbl[2].d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; tbl[2].tr = 1'b0;
        tbl[2].ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; tbl[2].ea = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        rst = 1'b1; start = 1'b0; transpose = 1'b0; in_data = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        chk_reset_outs("in_reset");
        rst = 1'b0;
        tick();
        chk_reset_outs("after_reset");

        // Start together with a valid beat: the beat must not be written.
        start = 1'b1; transpose = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        #1;
        chk("start_beat_w_en", w_en, 0);
        chk("start_beat_in_ready", in_ready, 0);
        tick();
        start = 1'b0; in_valid = 1'b0;
        do_txn(tbl[0].d, 1'b0, tbl[0].ed, tbl[0].ea, 0, 100, -1, 1'b0, 1'b1, -1);

        for (int i = 0; i < 3; i++)
            do_txn(tbl[i].d, tbl[i].tr, tbl[i].ed, tbl[i].ea, 0, 100, -1, 1'b1, 1'b0, -1);

        // Input gaps, 3-cycle stall on element 2, start pokes everywhere.
        do_txn(tbl[1].d, tbl[1].tr, tbl[1].ed, tbl[1].ea, 40, 100, 2, 1'b1, 1'b1, -1);

        // Reset on the second read element, then a fresh load.
        do_txn(tbl[0].d, 1'b0, tbl[0].ed, tbl[0].ea, 0, 100, -1, 1'b1, 1'b0, 1);
        do_txn(tbl[2].d, tbl[2].tr, tbl[2].ed, tbl[2].ea, 0, 100, -1, 1'b1, 1'b0, -1);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < DEPTH; i++) rd[i] = DS'($urandom);
            rtr = 1'($urandom_range(1));
            model(rd, rtr, red, rea);
            do_txn(rd, rtr, red, rea, 30, 60, int'($urandom_range(DEPTH - 1)), 1'b1, 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
